// File: rtl/bp_be_wb_merge_n_if.sv
// Writeback merge bundle: producer-side push channels, RF write port and fflags/status.
// The merge unit takes the slave modport; the driver of producers and the RF side takes master.
interface bp_be_wb_merge_n_if #(
    parameter int channels_p     = 2,
    parameter int data_width_p   = 64,
    parameter int rd_width_p     = 5,
    parameter int fflags_width_p = 5
);
    localparam int chan_w = (channels_p > 1) ? $clog2(channels_p) : 1;

    logic                                          flush_i;
    logic [channels_p-1:0]                         wb_v_i;
    logic [channels_p-1:0]                         wb_ready_o;
    logic [channels_p-1:0][rd_width_p-1:0]         wb_rd_i;
    logic [channels_p-1:0][data_width_p-1:0]       wb_data_i;
    logic [channels_p-1:0]                         wb_fflags_v_i;
    logic [channels_p-1:0][fflags_width_p-1:0]     wb_fflags_i;
    logic                                          rf_w_v_o;
    logic                                          rf_ready_i;
    logic [rd_width_p-1:0]                         rf_w_addr_o;
    logic [data_width_p-1:0]                       rf_w_data_o;
    logic [chan_w-1:0]                             rf_w_chan_o;
    logic [fflags_width_p-1:0]                     fflags_acc_o;
    logic                                          fflags_clr_i;
    logic                                          empty_o;

    modport slave (
        input  flush_i, wb_v_i, wb_rd_i, wb_data_i, wb_fflags_v_i, wb_fflags_i,
               rf_ready_i, fflags_clr_i,
        output wb_ready_o, rf_w_v_o, rf_w_addr_o, rf_w_data_o, rf_w_chan_o,
               fflags_acc_o, empty_o
    );

    modport master (
        output flush_i, wb_v_i, wb_rd_i, wb_data_i, wb_fflags_v_i, wb_fflags_i,
               rf_ready_i, fflags_clr_i,
        input  wb_ready_o, rf_w_v_o, rf_w_addr_o, rf_w_data_o, rf_w_chan_o,
               fflags_acc_o, empty_o
    );
endinterface

// File: rtl/bp_be_wb_merge_n.sv
// N-channel writeback merge: per-producer FIFOs drained round-robin to one RF write port,
// with x0-write elision and a sticky fflags accumulator.
module bp_be_wb_merge_n #(
    parameter int channels_p     = 2,
    parameter int data_width_p   = 64,
    parameter int rd_width_p     = 5,
    parameter int fifo_els_p     = 2,
    parameter int fflags_width_p = 5
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    bp_be_wb_merge_n_if.slave    io
);
    localparam int chan_w = (channels_p > 1) ? $clog2(channels_p) : 1;
    localparam int ptr_w  = $clog2(fifo_els_p);
    localparam int cnt_w  = ptr_w + 1;

    typedef struct packed {
        logic [rd_width_p-1:0]     rd;
        logic [data_width_p-1:0]   data;
        logic                      fv;
        logic [fflags_width_p-1:0] ff;
    } entry_t;

    typedef enum logic {ARB, HOLD} state_e;

    entry_t [fifo_els_p-1:0]          mem_q [channels_p];
    entry_t [fifo_els_p-1:0]          mem_d [channels_p];
    logic [channels_p-1:0][ptr_w-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [channels_p-1:0][cnt_w-1:0] cnt_q, cnt_d;
    logic [chan_w-1:0]                rr_q, rr_d, hold_chan_q, hold_chan_d;
    state_e                           state_q, state_d;
    logic [fflags_width_p-1:0]        acc_q, acc_d;

    logic [channels_p-1:0] nonempty, full, wb_ready;
    logic [chan_w-1:0]     arb_grant, grant, grant_inc;
    logic [chan_w:0]       scan_idx;
    logic                  found, head_v, rf_w_v, deq_fire;
    entry_t                head;

    always_comb begin
        for (int c = 0; c < channels_p; c++) begin
            nonempty[c] = (cnt_q[c] != '0);
            full[c]     = (cnt_q[c] == cnt_w'(fifo_els_p));
        end
        wb_ready = {channels_p{reset_n_i & ~io.flush_i}} & ~full;
    end

    // First non-empty channel at or after the RR pointer, wrapping at channels_p.
    always_comb begin
        arb_grant = rr_q;
        found     = 1'b0;
        scan_idx  = '0;
        for (int i = 0; i < channels_p; i++) begin
            scan_idx = {1'b0, rr_q} + (chan_w+1)'(i);
            if (scan_idx >= (chan_w+1)'(channels_p))
                scan_idx = scan_idx - (chan_w+1)'(channels_p);
            if (!found && nonempty[scan_idx[chan_w-1:0]]) begin
                arb_grant = scan_idx[chan_w-1:0];
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        grant     = (state_q == HOLD) ? hold_chan_q : arb_grant;
        grant_inc = (grant == chan_w'(channels_p - 1)) ? '0 : grant + chan_w'(1);
        head      = mem_q[grant][rptr_q[grant]];
        head_v    = reset_n_i & nonempty[grant];
        rf_w_v    = head_v & (head.rd != '0);
        // x0 entries drain on their own; the flush cycle never counts as a dequeue.
        deq_fire  = head_v & ~io.flush_i & ((head.rd == '0) | io.rf_ready_i);

        state_d     = state_q;
        hold_chan_d = hold_chan_q;
        case (state_q)
            ARB: if (rf_w_v && !io.rf_ready_i && !io.flush_i) begin
                state_d     = HOLD;
                hold_chan_d = grant;
            end
            HOLD: if (io.rf_ready_i || io.flush_i) state_d = ARB;
            default: state_d = ARB;
        endcase

        rr_d  = deq_fire ? grant_inc : rr_q;
        acc_d = io.fflags_clr_i ? '0 : acc_q;
        if (deq_fire && head.fv) acc_d = acc_d | head.ff;
    end

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        for (int c = 0; c < channels_p; c++) begin
            if (io.wb_v_i[c] && wb_ready[c]) begin
                mem_d[c][wptr_q[c]].rd   = io.wb_rd_i[c];
                mem_d[c][wptr_q[c]].data = io.wb_data_i[c];
                mem_d[c][wptr_q[c]].fv   = io.wb_fflags_v_i[c];
                mem_d[c][wptr_q[c]].ff   = io.wb_fflags_i[c];
                wptr_d[c] = wptr_q[c] + ptr_w'(1);
            end
            if (deq_fire && (grant == chan_w'(c)))
                rptr_d[c] = rptr_q[c] + ptr_w'(1);
            cnt_d[c] = cnt_q[c] + cnt_w'(io.wb_v_i[c] & wb_ready[c])
                     - cnt_w'(deq_fire && (grant == chan_w'(c)));
        end
        if (io.flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
        if (!reset_n_i) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            rr_q        <= '0;
            hold_chan_q <= '0;
            state_q     <= ARB;
            acc_q       <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            hold_chan_q <= hold_chan_d;
            state_q     <= state_d;
            acc_q       <= acc_d;
        end
    end

    assign io.wb_ready_o   = wb_ready;
    assign io.rf_w_v_o     = rf_w_v;
    assign io.rf_w_addr_o  = head.rd;
    assign io.rf_w_data_o  = head.data;
    assign io.rf_w_chan_o  = grant;
    assign io.fflags_acc_o = acc_q;
    assign io.empty_o      = ~reset_n_i | ~|nonempty;
endmodule

// File: tb/tb_bp_be_wb_merge_n.sv
// Directed bench for bp_be_wb_merge_n: a 2-channel and a 3-channel instance share clock/reset.
module tb_bp_be_wb_merge_n;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    int          ga[$];
    int          gc[$];
    logic [63:0] gd[$];

    bp_be_wb_merge_n_if #(.channels_p(2)) if2 ();
    bp_be_wb_merge_n_if #(.channels_p(3)) if3 ();

    bp_be_wb_merge_n #(.channels_p(2)) dut2 (.clk_i(clk), .reset_n_i(reset_n), .io(if2));
    bp_be_wb_merge_n #(.channels_p(3)) dut3 (.clk_i(clk), .reset_n_i(reset_n), .io(if3));

    always #5 clk = ~clk;

    function automatic logic [63:0] dval(input int rd);
        return 64'hA5A5_0000_0000_0000 | 64'(rd);
    endfunction

    task automatic clear_inputs();
        if2.flush_i = 1'b0; if2.fflags_clr_i = 1'b0; if2.wb_v_i = '0; if2.wb_rd_i = '0;
        if2.wb_data_i = '0; if2.wb_fflags_v_i = '0; if2.wb_fflags_i = '0;
        if3.flush_i = 1'b0; if3.fflags_clr_i = 1'b0; if3.wb_v_i = '0; if3.wb_rd_i = '0;
        if3.wb_data_i = '0; if3.wb_fflags_v_i = '0; if3.wb_fflags_i = '0;
    endtask

    task automatic push2(input logic [1:0] v, input int rd0, input int rd1);
        if2.wb_v_i = v;
        if2.wb_rd_i[0] = 5'(rd0); if2.wb_data_i[0] = dval(rd0);
        if2.wb_rd_i[1] = 5'(rd1); if2.wb_data_i[1] = dval(rd1);
    endtask

    task automatic sample2();
        if (if2.rf_w_v_o && if2.rf_ready_i) begin
            ga.push_back(int'(if2.rf_w_addr_o));
            gc.push_back(int'(if2.rf_w_chan_o));
            gd.push_back(if2.rf_w_data_o);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        if2.wb_v_i = '1; if3.wb_v_i = '1;
        if2.rf_ready_i = 1'b1; if3.rf_ready_i = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            checks++;
            if (if2.wb_ready_o !== 2'b00 || if3.wb_ready_o !== 3'b000) begin
                errors++;
                $display("FAIL reset_ready: got %b/%b exp 00/000", if2.wb_ready_o, if3.wb_ready_o);
            end
            checks++;
            if (if2.rf_w_v_o !== 1'b0 || if3.rf_w_v_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_rf_v: got %b/%b exp 0/0", if2.rf_w_v_o, if3.rf_w_v_o);
            end
            checks++;
            if (if2.empty_o !== 1'b1) begin
                errors++; $display("FAIL reset_empty: got %b exp 1", if2.empty_o);
            end
        end
        reset_n = 1'b1;
        if2.wb_v_i = '0; if3.wb_v_i = '0;
        @(negedge clk); #1;
        checks++;
        if (if2.empty_o !== 1'b1 || if3.empty_o !== 1'b1) begin
            errors++; $display("FAIL post_reset_empty: got %b/%b exp 1/1", if2.empty_o, if3.empty_o);
        end
        checks++;
        if (if2.rf_w_v_o !== 1'b0 || if3.rf_w_v_o !== 1'b0) begin
            errors++; $display("FAIL post_reset_rf_v: got %b/%b exp 0/0", if2.rf_w_v_o, if3.rf_w_v_o);
        end
        checks++;
        if (if2.fflags_acc_o !== 5'b0) begin
            errors++; $display("FAIL post_reset_acc: got %b exp 00000", if2.fflags_acc_o);
        end
        checks++;
        if (if2.wb_ready_o !== 2'b11 || if3.wb_ready_o !== 3'b111) begin
            errors++; $display("FAIL post_reset_ready: got %b/%b exp 11/111", if2.wb_ready_o, if3.wb_ready_o);
        end
    endtask

    task automatic test_round_robin();
        int ea[4];
        int ec[4];
        int got;
        ea = '{1, 3, 2, 4};
        ec = '{0, 1, 0, 1};
        ga.delete(); gc.delete(); gd.delete();
        if2.rf_ready_i = 1'b1;
        @(negedge clk); push2(2'b11, 1, 3);
        @(negedge clk); push2(2'b11, 2, 4); #1; sample2();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); if2.wb_v_i = '0; #1; sample2();
        end
        checks++;
        if (ga.size() != 4) begin
            errors++; $display("FAIL rr_count: got %0d writes exp 4", ga.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < ga.size()) ? ga[i] : -1;
            checks++;
            if (got != ea[i]) begin
                errors++; $display("FAIL rr_addr[%0d]: got %0d exp %0d", i, got, ea[i]);
            end
            got = (i < gc.size()) ? gc[i] : -1;
            checks++;
            if (got != ec[i]) begin
                errors++; $display("FAIL rr_chan[%0d]: got %0d exp %0d", i, got, ec[i]);
            end
            checks++;
            if (i < gd.size() && gd[i] !== dval(ea[i])) begin
                errors++; $display("FAIL rr_data[%0d]: got %0h exp %0h", i, gd[i], dval(ea[i]));
            end
        end
        checks++;
        if (if2.empty_o !== 1'b1) begin
            errors++; $display("FAIL rr_empty: got %b exp 1", if2.empty_o);
        end
    endtask

    task automatic test_fflags();
        if2.rf_ready_i = 1'b1;
        @(negedge clk);
        push2(2'b01, 0, 0); if2.wb_fflags_v_i = 2'b01; if2.wb_fflags_i[0] = 5'b00001;
        @(negedge clk); if2.wb_v_i = '0; #1;
        checks++;
        if (if2.rf_w_v_o !== 1'b0) begin
            errors++; $display("FAIL x0_no_write: got %b exp 0", if2.rf_w_v_o);
        end
        checks++;
        if (if2.fflags_acc_o !== 5'b00000) begin
            errors++; $display("FAIL x0_acc_before: got %b exp 00000", if2.fflags_acc_o);
        end
        @(negedge clk); #1;
        checks++;
        if (if2.fflags_acc_o !== 5'b00001) begin
            errors++; $display("FAIL x0_acc_after: got %b exp 00001", if2.fflags_acc_o);
        end
        checks++;
        if (if2.empty_o !== 1'b1 || if2.rf_w_v_o !== 1'b0) begin
            errors++; $display("FAIL x0_drained: got empty %b v %b exp 1 0", if2.empty_o, if2.rf_w_v_o);
        end
        // x0 entry on ch1 with fflags_v clear must not touch the accumulator.
        push2(2'b10, 0, 0); if2.wb_fflags_v_i = 2'b00; if2.wb_fflags_i[1] = 5'b11111;
        @(negedge clk); if2.wb_v_i = '0;
        @(negedge clk); #1;
        checks++;
        if (if2.fflags_acc_o !== 5'b00001 || if2.empty_o !== 1'b1) begin
            errors++; $display("FAIL fv0_ignored: got acc %b empty %b exp 00001 1", if2.fflags_acc_o, if2.empty_o);
        end
        push2(2'b01, 7, 0); if2.wb_fflags_v_i = 2'b01; if2.wb_fflags_i[0] = 5'b10000;
        @(negedge clk); if2.wb_v_i = '0; if2.fflags_clr_i = 1'b1; #1;
        checks++;
        if (if2.rf_w_v_o !== 1'b1 || if2.rf_w_addr_o !== 5'd7) begin
            errors++; $display("FAIL clr_deq_write: got v %b addr %0d exp 1 7", if2.rf_w_v_o, if2.rf_w_addr_o);
        end
        @(negedge clk); if2.fflags_clr_i = 1'b0; #1;
        checks++;
        if (if2.fflags_acc_o !== 5'b10000) begin
            errors++; $display("FAIL clr_with_deq: got %b exp 10000", if2.fflags_acc_o);
        end
        if2.wb_fflags_v_i = '0; if2.wb_fflags_i = '0;
    endtask

    task automatic test_hold();
        int ea[3];
        int got;
        ea = '{5, 9, 6};
        ga.delete(); gc.delete(); gd.delete();
        @(negedge clk); if2.rf_ready_i = 1'b0; push2(2'b01, 5, 0);
        @(negedge clk); push2(2'b01, 6, 0); #1;
        checks++;
        if (if2.rf_w_v_o !== 1'b1 || if2.rf_w_addr_o !== 5'd5) begin
            errors++; $display("FAIL hold_first: got v %b addr %0d exp 1 5", if2.rf_w_v_o, if2.rf_w_addr_o);
        end
        @(negedge clk); push2(2'b11, 7, 9); #1;
        checks++;
        if (if2.wb_ready_o !== 2'b10) begin
            errors++; $display("FAIL hold_full_ready: got %b exp 10", if2.wb_ready_o);
        end
        checks++;
        if (if2.rf_w_addr_o !== 5'd5 || if2.rf_w_chan_o !== 1'b0 || if2.rf_w_data_o !== dval(5)) begin
            errors++; $display("FAIL hold_stable: got addr %0d chan %0d data %0h exp 5 0 %0h",
                               if2.rf_w_addr_o, if2.rf_w_chan_o, if2.rf_w_data_o, dval(5));
        end
        @(negedge clk); if2.wb_v_i = '0; #1;
        checks++;
        if (if2.rf_w_v_o !== 1'b1 || if2.rf_w_addr_o !== 5'd5 || if2.rf_w_chan_o !== 1'b0) begin
            errors++; $display("FAIL hold_vs_ch1: got v %b addr %0d chan %0d exp 1 5 0",
                               if2.rf_w_v_o, if2.rf_w_addr_o, if2.rf_w_chan_o);
        end
        @(negedge clk); if2.rf_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            #1; sample2();
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < ga.size()) ? ga[i] : -1;
            checks++;
            if (got != ea[i]) begin
                errors++; $display("FAIL hold_release[%0d]: got %0d exp %0d", i, got, ea[i]);
            end
        end
        checks++;
        if (ga.size() != 3 || if2.empty_o !== 1'b1) begin
            errors++; $display("FAIL hold_drain: got %0d writes empty %b exp 3 1", ga.size(), if2.empty_o);
        end
    endtask

    task automatic test_flush();
        int nwr;
        int got;
        ga.delete(); gc.delete(); gd.delete();
        @(negedge clk); if2.rf_ready_i = 1'b0; push2(2'b11, 1, 3);
        if2.wb_fflags_v_i = 2'b11; if2.wb_fflags_i[0] = 5'b00011; if2.wb_fflags_i[1] = 5'b00011;
        @(negedge clk); push2(2'b11, 2, 4);
        @(negedge clk); if2.wb_v_i = '0; #1;
        checks++;
        if (if2.wb_ready_o !== 2'b00 || if2.empty_o !== 1'b0) begin
            errors++; $display("FAIL flush_pre: got ready %b empty %b exp 00 0", if2.wb_ready_o, if2.empty_o);
        end
        if2.flush_i = 1'b1;
        @(negedge clk); if2.flush_i = 1'b0; if2.wb_fflags_v_i = '0; #1;
        checks++;
        if (if2.empty_o !== 1'b1 || if2.rf_w_v_o !== 1'b0) begin
            errors++; $display("FAIL flush_empty: got empty %b v %b exp 1 0", if2.empty_o, if2.rf_w_v_o);
        end
        checks++;
        if (if2.fflags_acc_o !== 5'b10000) begin
            errors++; $display("FAIL flush_acc: got %b exp 10000", if2.fflags_acc_o);
        end
        if2.rf_ready_i = 1'b1;
        nwr = 0;
        repeat (2) begin
            @(negedge clk); #1;
            if (if2.rf_w_v_o) nwr++;
        end
        checks++;
        if (nwr != 0) begin
            errors++; $display("FAIL flush_no_writes: got %0d writes exp 0", nwr);
        end
        // RR pointer survives flush: it was left at ch1, so ch1 wins first.
        @(negedge clk); push2(2'b11, 10, 11);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); if2.wb_v_i = '0; #1; sample2();
        end
        got = (ga.size() > 0) ? ga[0] : -1;
        checks++;
        if (got != 11) begin
            errors++; $display("FAIL flush_rr_first: got %0d exp 11", got);
        end
        got = (ga.size() > 1) ? ga[1] : -1;
        checks++;
        if (got != 10) begin
            errors++; $display("FAIL flush_rr_second: got %0d exp 10", got);
        end
    endtask

    task automatic test_rr3();
        int ec[6];
        int ea[6];
        int cnt[3];
        logic [2:0] exp_rdy;
        int got;
        ec = '{0, 1, 2, 0, 1, 2};
        ea = '{1, 3, 5, 2, 4, 6};
        cnt = '{2, 2, 2};
        ga.delete(); gc.delete();
        @(negedge clk); if3.rf_ready_i = 1'b0; if3.wb_v_i = 3'b111;
        if3.wb_rd_i[0] = 5'd1; if3.wb_rd_i[1] = 5'd3; if3.wb_rd_i[2] = 5'd5;
        @(negedge clk);
        if3.wb_rd_i[0] = 5'd2; if3.wb_rd_i[1] = 5'd4; if3.wb_rd_i[2] = 5'd6;
        @(negedge clk);
        if3.wb_rd_i[0] = 5'd31; if3.wb_rd_i[1] = 5'd31; if3.wb_rd_i[2] = 5'd31; #1;
        checks++;
        if (if3.wb_ready_o !== 3'b000) begin
            errors++; $display("FAIL rr3_full_ready: got %b exp 000", if3.wb_ready_o);
        end
        checks++;
        if (if3.rf_w_v_o !== 1'b1 || if3.rf_w_addr_o !== 5'd1 || if3.rf_w_chan_o !== 2'd0) begin
            errors++; $display("FAIL rr3_first: got v %b addr %0d chan %0d exp 1 1 0",
                               if3.rf_w_v_o, if3.rf_w_addr_o, if3.rf_w_chan_o);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if3.wb_v_i = '0;
            if3.rf_ready_i = (k % 2 == 0);
            #1;
            for (int c = 0; c < 3; c++) exp_rdy[c] = (cnt[c] < 2);
            checks++;
            if (if3.wb_ready_o !== exp_rdy) begin
                errors++; $display("FAIL rr3_ready[%0d]: got %b exp %b", k, if3.wb_ready_o, exp_rdy);
            end
            if (if3.rf_w_v_o && if3.rf_ready_i) begin
                ga.push_back(int'(if3.rf_w_addr_o));
                gc.push_back(int'(if3.rf_w_chan_o));
                if (int'(if3.rf_w_chan_o) < 3) cnt[int'(if3.rf_w_chan_o)]--;
            end
        end
        for (int i = 0; i < 6; i++) begin
            got = (i < gc.size()) ? gc[i] : -1;
            checks++;
            if (got != ec[i]) begin
                errors++; $display("FAIL rr3_chan[%0d]: got %0d exp %0d", i, got, ec[i]);
            end
            got = (i < ga.size()) ? ga[i] : -1;
            checks++;
            if (got != ea[i]) begin
                errors++; $display("FAIL rr3_addr[%0d]: got %0d exp %0d", i, got, ea[i]);
            end
        end
        checks++;
        if (if3.empty_o !== 1'b1) begin
            errors++; $display("FAIL rr3_empty: got %b exp 1", if3.empty_o);
        end
    endtask

    initial begin
        clk = 1'b0;
        reset_n = 1'b0;
        checks = 0;
        errors = 0;
        clear_inputs();
        if2.rf_ready_i = 1'b0;
        if3.rf_ready_i = 1'b0;
        test_reset();
        test_round_robin();
        test_fflags();
        test_hold();
        test_flush();
        test_rr3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
